dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-ported, byte-addressed 64-bit data memory.
- Requester 0 is the pipeline MEM stage; requester 1 is the loader/debug port.
- Grants one access per service cycle using round-robin priority, with a registered grant.
- Range-checks every address before driving the memory: illegal accesses never reach the memory; they return an error response and set a sticky fault.

Parameters:
- MEM_BYTES, 1024: memory size in bytes.
- ACC_BYTES, 8: bytes per access; the last legal address is MEM_BYTES-ACC_BYTES (1016).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held until m0_ready.
- m0_we  in  1  requester 0: 1=store, 0=load.
- m0_addr  in  64  requester 0 byte address.
- m0_wdata  in  64  requester 0 store data (signed).
- m0_ready  out  1  requester 0 access complete, one-cycle pulse.
- m0_rdata  out  64  requester 0 load data, valid only while m0_ready=1.
- m0_err  out  1  requester 0 access was out of range, qualified by m0_ready.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err: same as above for requester 1.
- mem_address  out  64  to data memory.
- mem_write_data  out  64  to data memory.
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_read_data  in  64  from data memory; combinational read.
- fault  out  1  sticky: an out-of-range access has occurred.
- fault_addr  out  64  address of the first faulting access.

Behaviour:
- Reset (asynchronous): state=IDLE, owner=0, last=1 (so requester 0 wins the first tie). All outputs are 0, including fault and fault_addr.
- State machine:
  - IDLE: no memory strobes, no ready.
    - If exactly one req is high, go to SERV with owner = that requester.
    - If both are high, owner = ~last.
  - SERV: one cycle.
    - Memory outputs are driven from the owner's addr/wdata.
    - Owner's ready=1. The other requester's ready stays 0.
    - Load: rdata = mem_read_data in the same cycle.
    - Store: the write commits at the rising edge that ends SERV.
    - On that edge: last <= owner.
    - Next state: if the non-owner's req is high, stay in SERV with owner = non-owner (back-to-back handoff). Otherwise go to IDLE.
    - The owner's still-high req is ignored in the SERV cycle.
- Latency: from a req first seen in IDLE, ready arrives in the next cycle (1 cycle).
  - A lone requester issuing continuously gets one access every 2 cycles.
  - With both requesters continuously requesting, accesses alternate every cycle.
- Range check, applied in SERV:
  - The check is illegal = addr > MEM_BYTES-ACC_BYTES, as an unsigned 64-bit compare.
  - If illegal: mem_read=mem_write=0, mem_address=0, owner's ready=1, err=1, rdata=0.
  - On the first illegal access only: fault<=1 and fault_addr<=addr. Later faults leave fault_addr unchanged.
  - fault clears only on reset.
- Unused outputs in any cycle are 0 (mem_*, rdata, err, ready).
- Requester rule: req/we/addr/wdata must be held stable from assertion until ready. The arbiter does not register the request payload.
- Reset mid-SERV:
  - The memory strobes drop immediately.
  - A store whose edge had not yet occurred is not performed.
  - The requester re-issues after reset.
- A req dropped before ready is protocol-illegal. If it happens in SERV, the access still completes.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, SERV};
  - MEM_LIMIT = MEM_BYTES-ACC_BYTES;
  - requester-index constants REQ_PIPE=0 and REQ_LOAD=1.
- Sub-module rr_pick2: a combinational two-input round-robin selector, with inputs req[1:0] and last, and outputs gnt_valid and gnt_idx.
- Everything else lives in dmem_arbiter.

Test Plan:
- Single load: mem[16..23]=0x1122334455667788; m0 load addr=16 -> m0_ready one cycle after req, m0_rdata=0x1122334455667788, m0_err=0, mem_write=0.
- Contention after reset: m0 and m1 assert req in the same cycle (stores of 0xA to addr 0 and 0xB to addr 8) -> m0 served in cycle 1, m1 in cycle 2, no IDLE gap; readback gives mem[0]=0xA and mem[8]=0xB.
- Round-robin fairness: both requesters hold req for 6 accesses -> grants alternate 0,1,0,1,0,1 and neither requester waits more than 1 service cycle.
- Bounds: m1 load addr=1017 -> m1_ready=1, m1_err=1, m1_rdata=0, mem_read never asserted, fault=1, fault_addr=1017; a following access at addr=2000 leaves fault_addr=1017. Boundary addr=1016 -> err=0 and normal data.
- Reset mid-operation: m0 store of 0xFF to addr 24, with reset asserted during the SERV cycle before the edge -> mem_write drops to 0 asynchronously, mem[24] unchanged, all outputs 0; after release, the first tie is granted to m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants for the data-memory arbiter.
//   - default memory geometry and the last legal access address
//   - FSM state encodings (IDLE / SERV)
//   - requester index constants
//   - helper for the address range check
package dmem_arb_pkg;

  localparam int MEM_BYTES_DEF = 1024;
  localparam int ACC_BYTES_DEF = 8;
  localparam int MEM_LIMIT     = MEM_BYTES_DEF - ACC_BYTES_DEF;

  // FSM state encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SERV = 1'b1;

  // Requester indices
  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  // An access is illegal when it would run past the end of memory.
  // Unsigned 64-bit compare: huge addresses are illegal, never wrapped.
  function automatic logic addr_illegal(input logic [63:0] addr,
                                        input logic [63:0] limit);
    return addr > limit;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-input round-robin selector.
//   req[1:0]  in   request lines, bit i = requester i
//   last      in   index of the requester served most recently
//   gnt_valid out  at least one request is pending
//   gnt_idx   out  chosen requester (the one not served last on a tie)
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~last
                   : (req[REQ_LOAD] ? REQ_LOAD : REQ_PIPE);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported 64-bit data memory between the
// pipeline MEM stage (requester 0) and the loader/debug port (requester 1).
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   mX_req/we/addr/wdata           requester X access (held until mX_ready)
//   mX_ready/rdata/err             requester X completion pulse, load data, range error
//   mem_address/write_data/read/write  strobes to the data memory
//   mem_read_data                  combinational read data from memory
//   fault, fault_addr              sticky out-of-range flag and first faulting address
//   fsm_state                      current FSM state (IDLE/SERV) for observation
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees ready high for one cycle; the access completes in that
// cycle (load data valid only while ready=1, store commits at the edge that
// ends it). The payload is not registered, so the muxed request drives the
// memory directly during SERV.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ACC_BYTES = ACC_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_ready,
  output logic [63:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_ready,
  output logic [63:0] m1_rdata,
  output logic        m1_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data,
  output logic        fault,
  output logic [63:0] fault_addr,
  output logic [0:0]  fsm_state
);

  localparam logic [63:0] LIMIT = 64'(MEM_BYTES - ACC_BYTES);

  logic [0:0]  state, state_nx;
  logic        owner, owner_nx;
  logic        last;
  logic        gnt_valid, gnt_idx;
  logic        serving, cur_we, illegal, access_ok, other_req;
  logic [63:0] cur_addr, cur_wdata;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign serving   = (state == SERV);
  assign cur_we    = (owner == REQ_LOAD) ? m1_we    : m0_we;
  assign cur_addr  = (owner == REQ_LOAD) ? m1_addr  : m0_addr;
  assign cur_wdata = (owner == REQ_LOAD) ? m1_wdata : m0_wdata;
  assign other_req = (owner == REQ_LOAD) ? m0_req   : m1_req;
  assign illegal   = addr_illegal(cur_addr, LIMIT);
  assign access_ok = serving && !illegal;

  // Memory strobes: only a legal access in SERV reaches the memory.
  assign mem_address    = access_ok ? cur_addr : 64'd0;
  assign mem_write_data = (access_ok && cur_we) ? cur_wdata : 64'd0;
  assign mem_read       = access_ok && !cur_we;
  assign mem_write      = access_ok && cur_we;

  // Responses
  assign m0_ready = serving && (owner == REQ_PIPE);
  assign m1_ready = serving && (owner == REQ_LOAD);
  assign m0_err   = m0_ready && illegal;
  assign m1_err   = m1_ready && illegal;
  assign m0_rdata = (m0_ready && mem_read) ? mem_read_data : 64'd0;
  assign m1_rdata = (m1_ready && mem_read) ? mem_read_data : 64'd0;

  assign fsm_state = state;

  // In SERV the owner's own req is ignored: only the other requester can
  // extend service, which gives back-to-back alternation under contention.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    if (state == IDLE) begin
      if (gnt_valid) begin
        state_nx = SERV;
        owner_nx = gnt_idx;
      end
    end else begin
      if (other_req) begin
        owner_nx = ~owner;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= REQ_PIPE;
      last       <= REQ_LOAD;   // requester 0 wins the first tie
      fault      <= 1'b0;
      fault_addr <= 64'd0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      if (serving) begin
        last <= owner;
      end
      // Only the first fault is recorded; later ones leave fault_addr alone.
      if (serving && illegal && !fault) begin
        fault      <= 1'b1;
        fault_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// word-array memory model attached to the memory port.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data, fault_addr;
  logic        mem_read, mem_write, fault;
  logic [0:0]  fsm_state;

  localparam logic [63:0] W16   = 64'h1122334455667788;
  localparam logic [63:0] W24   = 64'h0123456789ABCDEF;
  localparam logic [63:0] W1016 = 64'hFEEDFACECAFEF00D;

  logic [63:0] mem [0:127];
  logic [63:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_ready       (m0_ready),
    .m0_rdata       (m0_rdata),
    .m0_err         (m0_err),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_ready       (m1_ready),
    .m1_rdata       (m1_rdata),
    .m1_err         (m1_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fsm_state      (fsm_state)
  );

  // Memory model: combinational read, write at the rising edge.
  assign mem_read_data = mem[mem_address[9:3]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:3]] <= mem_write_data;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic do_reset;
    next_cycle;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Watchdog: the directed sequence is fixed-length, this only guards hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [63:0] g;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'hA5A5000000000000 | 64'(i);
    mem[2]   = W16;
    mem[3]   = W24;
    mem[127] = W1016;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);
    reset = 1'b1;

    // Reset state: every output zero.
    @(negedge clk);
    check("rst_flags", {m0_ready, m0_err, m1_ready, m1_err, mem_read, mem_write, fault}, 64'd0);
    check("rst_data", m0_rdata | m1_rdata | mem_address | mem_write_data | fault_addr, 64'd0);
    check("rst_state", fsm_state, IDLE);
    #2 reset = 1'b0;

    // ---- single load, m0 addr 16 ----
    next_cycle;
    drive_m0(1'b1, 1'b0, 64'd16, 64'd0);
    @(negedge clk);
    check("ld_idle_ready", m0_ready, 1'b0);
    next_cycle;
    @(negedge clk);
    check("ld_ready", m0_ready, 1'b1);
    check("ld_rdata", m0_rdata, W16);
    check("ld_err", m0_err, 1'b0);
    check("ld_mem_write", mem_write, 1'b0);
    check("ld_mem_read", mem_read, 1'b1);
    check("ld_m1_ready", m1_ready, 1'b0);
    next_cycle;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("ld_after_ready", m0_ready, 1'b0);
    check("ld_after_state", fsm_state, IDLE);

    // ---- contention after reset: stores 0xA@0 (m0), 0xB@8 (m1) ----
    do_reset;
    drive_m0(1'b1, 1'b1, 64'd0, 64'hA);
    drive_m1(1'b1, 1'b1, 64'd8, 64'hB);
    @(negedge clk);
    check("ct_idle", {m0_ready, m1_ready}, 2'b00);
    next_cycle;
    @(negedge clk);
    check("ct_c1_ready", {m0_ready, m1_ready}, 2'b10);
    check("ct_c1_addr", mem_address, 64'd0);
    check("ct_c1_wdata", mem_write_data, 64'hA);
    check("ct_c1_we", mem_write, 1'b1);
    next_cycle;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("ct_c2_ready", {m0_ready, m1_ready}, 2'b01);
    check("ct_c2_addr", mem_address, 64'd8);
    check("ct_c2_wdata", mem_write_data, 64'hB);
    next_cycle;
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);
    check("ct_mem0", mem[0], 64'hA);
    check("ct_mem8", mem[1], 64'hB);
    drive_m0(1'b1, 1'b0, 64'd8, 64'd0);
    next_cycle;
    @(negedge clk);
    check("ct_readback", m0_rdata, 64'hB);
    next_cycle;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);

    // ---- round-robin fairness: both hold req for 6 accesses ----
    do_reset;
    for (int i = 0; i < 6; i++) exp_q.push_back(64'(i % 2));
    drive_m0(1'b1, 1'b0, 64'd16, 64'd0);
    drive_m1(1'b1, 1'b0, 64'd1016, 64'd0);
    @(negedge clk);
    check("rr_idle", {m0_ready, m1_ready}, 2'b00);
    next_cycle;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) m0_req = 1'b0;   // m0 was served in the previous cycle
      @(negedge clk);
      g = exp_q.pop_front();
      check("rr_m0_ready", m0_ready, g == 64'd0);
      check("rr_m1_ready", m1_ready, g == 64'd1);
      check("rr_rdata", m0_ready ? m0_rdata : m1_rdata, (g == 64'd0) ? W16 : W1016);
      next_cycle;
    end
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("rr_end_state", fsm_state, IDLE);
    check("rr_end_ready", {m0_ready, m1_ready}, 2'b00);

    // ---- bounds ----
    do_reset;
    drive_m1(1'b1, 1'b0, 64'd1017, 64'd0);
    @(negedge clk);
    check("bd_fault_pre", fault, 1'b0);
    next_cycle;
    @(negedge clk);
    check("bd_ready", m1_ready, 1'b1);
    check("bd_err", m1_err, 1'b1);
    check("bd_rdata", m1_rdata, 64'd0);
    check("bd_mem_read", mem_read, 1'b0);
    check("bd_mem_addr", mem_address, 64'd0);
    next_cycle;
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("bd_fault", fault, 1'b1);
    check("bd_fault_addr", fault_addr, 64'd1017);
    drive_m0(1'b1, 1'b1, 64'd2000, 64'h55);
    next_cycle;
    @(negedge clk);
    check("bd2_ready_err", {m0_ready, m0_err}, 2'b11);
    check("bd2_mem_write", mem_write, 1'b0);
    next_cycle;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("bd2_fault_addr", fault_addr, 64'd1017);
    check("bd2_fault", fault, 1'b1);
    drive_m1(1'b1, 1'b0, 64'd1016, 64'd0);
    next_cycle;
    @(negedge clk);
    check("bd3_err", m1_err, 1'b0);
    check("bd3_rdata", m1_rdata, W1016);
    check("bd3_mem_read", mem_read, 1'b1);
    next_cycle;
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);

    // ---- reset during SERV of a store ----
    drive_m0(1'b1, 1'b1, 64'd24, 64'hFF);
    next_cycle;
    @(negedge clk);
    check("rm_write_before", mem_write, 1'b1);
    next_cycle;   // lands mid-window? no: we need to be inside SERV, redo below
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    check("rm_store_done", mem[3], 64'hFF);
    mem[3] = W24;
    drive_m0(1'b1, 1'b1, 64'd24, 64'hFF);
    next_cycle;   // SERV begins here
    #1;
    reset = 1'b1;
    #1;
    check("rm_write_drop", mem_write, 1'b0);
    check("rm_flags", {m0_ready, m0_err, m1_ready, m1_err, mem_read, mem_write, fault}, 64'd0);
    check("rm_state", fsm_state, IDLE);
    next_cycle;
    check("rm_mem_keep", mem[3], W24);
    drive_m0(1'b1, 1'b0, 64'd24, 64'd0);
    drive_m1(1'b1, 1'b0, 64'd16, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rm_post_idle", {m0_ready, m1_ready}, 2'b00);
    next_cycle;
    @(negedge clk);
    check("rm_tie_ready", {m0_ready, m1_ready}, 2'b10);
    check("rm_tie_rdata", m0_rdata, W24);
    next_cycle;
    drive_m0(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("rm_tie2_ready", {m0_ready, m1_ready}, 2'b01);
    check("rm_tie2_rdata", m1_rdata, W16);
    next_cycle;
    drive_m1(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("rm_end_state", fsm_state, IDLE);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
